// File: rtl/inst_fetcher.sv
// inst_fetcher: front-end fetch stage feeding the instruction decoder.
//
// Issues one 32-bit fetch at a time to the instruction cache, holds the
// returned word with its PC and a 2-bit BHT prediction until the decoder
// accepts it, and follows decoder redirects and RoB flushes.
//
// Ports:
//   clk_in, rst_in        system clock, synchronous active-high reset
//   rdy_in                global ready; low freezes all state (reset still acts)
//   icache_req/addr       fetch request and its address (stable while req=1)
//   icache_valid/inst     one-cycle response pulse and returned word
//   fetch_ready           inst/pc/pred_res valid for the decoder
//   inst, pc, pred_res    held instruction, its PC, BHT prediction (1=taken)
//   issue_ready           decoder consumes the held instruction
//   pc_change_flag/pc_change  decoder redirect, qualified by issue_ready
//   rob_clear/rob_pc_new  RoB flush and restart PC
//   br_upd_valid/pc/taken committed branch outcome for BHT training
//
// state   | meaning
// S_REQ   | request outstanding at fetch_pc
// S_HOLD  | instruction presented to the decoder
// S_DISCARD | flush hit an outstanding request; drop the stale response

module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        pred_res,
  input  logic        issue_ready,
  input  logic        pc_change_flag,
  input  logic [31:0] pc_change,
  input  logic        rob_clear,
  input  logic [31:0] rob_pc_new,
  input  logic        br_upd_valid,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam int BHT_SIZE = 1 << BHT_BITS;

  logic [1:0]          state, state_nxt;
  logic [31:0]         fetch_pc, fetch_pc_nxt;
  logic [31:0]         addr_nxt;
  logic                capture;
  logic [1:0]          bht [BHT_SIZE];
  logic [BHT_BITS-1:0] look_idx, upd_idx;
  logic                unused_upd_bits;

  assign look_idx = fetch_pc[BHT_BITS+1:2];
  assign upd_idx  = br_upd_pc[BHT_BITS+1:2];
  assign unused_upd_bits = ^{br_upd_pc[31:BHT_BITS+2], br_upd_pc[1:0]};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    capture      = 1'b0;
    if (rob_clear) begin
      fetch_pc_nxt = rob_pc_new;
      // A response landing in the flush cycle is dropped here, so only a
      // still-outstanding request needs the DISCARD detour.
      if (state == S_HOLD || (state == S_REQ && icache_valid))
        state_nxt = S_REQ;
      else
        state_nxt = S_DISCARD;
    end else begin
      case (state)
        S_REQ: begin
          if (icache_valid) begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (issue_ready) begin
            fetch_pc_nxt = pc_change_flag ? pc_change : pc + 32'd4;
            state_nxt    = S_REQ;
          end
        end
        S_DISCARD: begin
          if (icache_valid) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
    // The cache still owes a response for the old address while discarding.
    addr_nxt = (state_nxt == S_DISCARD) ? icache_addr : fetch_pc_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      icache_addr <= RESET_PC;
      icache_req  <= 1'b0;
      fetch_ready <= 1'b0;
      inst        <= 32'h0;
      pc          <= 32'h0;
      pred_res    <= 1'b0;
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (rdy_in) begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      icache_addr <= addr_nxt;
      icache_req  <= (state_nxt != S_HOLD);
      fetch_ready <= (state_nxt == S_HOLD);
      if (capture) begin
        inst     <= icache_inst;
        pc       <= fetch_pc;
        pred_res <= bht[look_idx][1];
      end
      // Lookup above reads the pre-update counter on an index collision.
      if (br_upd_valid) begin
        if (br_upd_taken && bht[upd_idx] != 2'b11)
          bht[upd_idx] <= bht[upd_idx] + 2'b01;
        else if (!br_upd_taken && bht[upd_idx] != 2'b00)
          bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        fetch_ready;
  logic [31:0] inst, pc;
  logic        pred_res;
  logic        issue_ready, pc_change_flag;
  logic [31:0] pc_change;
  logic        rob_clear;
  logic [31:0] rob_pc_new;
  logic        br_upd_valid;
  logic [31:0] br_upd_pc;
  logic        br_upd_taken;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk_in = ~clk_in;

  inst_fetcher #(.RESET_PC(32'h0), .BHT_BITS(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_inst(icache_inst),
    .fetch_ready(fetch_ready), .inst(inst), .pc(pc), .pred_res(pred_res),
    .issue_ready(issue_ready), .pc_change_flag(pc_change_flag),
    .pc_change(pc_change), .rob_clear(rob_clear), .rob_pc_new(rob_pc_new),
    .br_upd_valid(br_upd_valid), .br_upd_pc(br_upd_pc),
    .br_upd_taken(br_upd_taken)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracked as "holding an instruction" and "a stale response is owed"
  // flags plus the next address to fetch; BHT as plain integer counters.
  bit          m_have, m_stale;
  logic [31:0] m_fpc;
  logic        e_req, e_pred;
  logic [31:0] e_addr, e_inst, e_pc;
  int          m_bht [256];

  function automatic int bidx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  always @(posedge clk_in) begin
    bit old_pred;
    if (rst_in) begin
      m_have = 0; m_stale = 0; m_fpc = 32'h0;
      e_addr = 32'h0; e_req = 0; e_inst = 0; e_pc = 0; e_pred = 0;
      for (int i = 0; i < 256; i++) m_bht[i] = 1;
    end else if (rdy_in) begin
      old_pred = (m_bht[bidx(m_fpc)] >= 2);
      if (br_upd_valid) begin
        if (br_upd_taken) m_bht[bidx(br_upd_pc)] = (m_bht[bidx(br_upd_pc)] == 3) ? 3 : m_bht[bidx(br_upd_pc)] + 1;
        else              m_bht[bidx(br_upd_pc)] = (m_bht[bidx(br_upd_pc)] == 0) ? 0 : m_bht[bidx(br_upd_pc)] - 1;
      end
      if (rob_clear) begin
        m_fpc = rob_pc_new;
        e_req = 1;
        if (m_have || (!m_stale && icache_valid)) begin
          m_stale = 0; e_addr = m_fpc;
        end else begin
          m_stale = 1;
        end
        m_have = 0;
      end else if (m_have) begin
        if (issue_ready) begin
          m_fpc = pc_change_flag ? pc_change : e_pc + 32'd4;
          m_have = 0; e_req = 1; e_addr = m_fpc;
        end
      end else if (m_stale) begin
        if (icache_valid) begin
          m_stale = 0; e_addr = m_fpc; e_req = 1;
        end
      end else begin
        e_req = 1; e_addr = m_fpc;
        if (icache_valid) begin
          e_inst = icache_inst; e_pc = m_fpc; e_pred = old_pred;
          m_have = 1; e_req = 0;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, m_have});
      chk("icache_req",  {31'b0, icache_req},  {31'b0, e_req});
      if (e_req) chk("icache_addr", icache_addr, e_addr);
      chk("inst", inst, e_inst);
      chk("pc", pc, e_pc);
      chk("pred_res", {31'b0, pred_res}, {31'b0, e_pred});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic respond(input logic [31:0] d);
    icache_valid = 1; icache_inst = d;
    cyc(1);
    icache_valid = 0;
  endtask

  task automatic issue(input logic flag, input logic [31:0] tgt);
    issue_ready = 1; pc_change_flag = flag; pc_change = tgt;
    cyc(1);
    issue_ready = 0; pc_change_flag = 0;
  endtask

  task automatic br(input logic [31:0] a, input logic tk, input int n);
    br_upd_valid = 1; br_upd_pc = a; br_upd_taken = tk;
    cyc(n);
    br_upd_valid = 0;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; icache_valid = 0; icache_inst = 0;
    issue_ready = 0; pc_change_flag = 0; pc_change = 0;
    rob_clear = 0; rob_pc_new = 0;
    br_upd_valid = 0; br_upd_pc = 0; br_upd_taken = 0;
    cyc(1);
    chk_en = 1;
    cyc(1);
    chk("rst req", {31'b0, icache_req}, 32'd0);
    chk("rst ready", {31'b0, fetch_ready}, 32'd0);
    chk("rst addr", icache_addr, 32'h0);
    rst_in = 0;
    cyc(1);
    chk("first req", {31'b0, icache_req}, 32'd1);
    cyc(1);
    respond(32'h00000013);
    chk("t1 ready", {31'b0, fetch_ready}, 32'd1);
    chk("t1 inst", inst, 32'h13);
    chk("t1 pc", pc, 32'h0);
    chk("t1 pred", {31'b0, pred_res}, 32'd0);
    issue(0, 32'h0);
    chk("t1 next addr", icache_addr, 32'h4);
    chk("t1 next req", {31'b0, icache_req}, 32'd1);

    // redirect and PC wrap; a stray response while holding is ignored
    respond(32'h00A00093);
    icache_valid = 1; icache_inst = 32'hCAFEF00D; cyc(1); icache_valid = 0;
    chk("hold ignores valid", inst, 32'h00A00093);
    issue(1, 32'h100);
    chk("redirect addr", icache_addr, 32'h100);
    respond(32'h00000013);
    issue(1, 32'hFFFFFFFC);
    cyc(1);
    respond(32'h00000063);
    chk("wrap pc", pc, 32'hFFFFFFFC);
    issue(0, 32'h0);
    chk("wrap addr", icache_addr, 32'h0);

    // BHT training
    br(32'h40, 1, 2);
    respond(32'h00000013);
    issue(1, 32'h40);
    respond(32'hFE000EE3);
    chk("bht taken pred", {31'b0, pred_res}, 32'd1);
    issue(1, 32'h40);
    br(32'h40, 0, 4);
    br(32'h40, 1, 1);
    br_upd_valid = 1; br_upd_pc = 32'h40; br_upd_taken = 1;
    respond(32'hFE000EE3);
    br_upd_valid = 0;
    chk("bht floor/pre-update pred", {31'b0, pred_res}, 32'd0);
    issue(1, 32'h40);
    respond(32'hFE000EE3);
    chk("bht after collide pred", {31'b0, pred_res}, 32'd1);

    // flush with outstanding request
    issue(1, 32'h8);
    rob_clear = 1; rob_pc_new = 32'h200;
    cyc(1);
    rob_clear = 0;
    chk("discard stale addr", icache_addr, 32'h8);
    cyc(1);
    respond(32'hDEADBEEF);
    chk("discard no ready", {31'b0, fetch_ready}, 32'd0);
    chk("discard new addr", icache_addr, 32'h200);
    respond(32'h00000013);
    chk("after discard pc", pc, 32'h200);

    // flush beats a same-cycle redirect
    issue_ready = 1; pc_change_flag = 1; pc_change = 32'h300;
    rob_clear = 1; rob_pc_new = 32'h500;
    cyc(1);
    issue_ready = 0; pc_change_flag = 0; rob_clear = 0;
    chk("flush prio ready", {31'b0, fetch_ready}, 32'd0);
    chk("flush prio addr", icache_addr, 32'h500);
    respond(32'h12345678);

    // global stall while the decoder wants to advance
    issue_ready = 1; rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall ready", {31'b0, fetch_ready}, 32'd1);
      chk("stall pc", pc, 32'h500);
      chk("stall inst", inst, 32'h12345678);
    end
    rdy_in = 1;
    cyc(1);
    issue_ready = 0;
    chk("unstall ready", {31'b0, fetch_ready}, 32'd0);
    chk("unstall addr", icache_addr, 32'h504);
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
